// File: rtl/icb_arb_2m1s_pkg.sv
// Shared ICB bus widths and the arbiter state encoding.
package icb_arb_2m1s_pkg;

  localparam int unsigned MemAddrBus = 32;
  localparam int unsigned MemBus     = 32;
  localparam int unsigned MemMaskBus = MemBus / 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_RSP  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/icb_arb_2m1s_if.sv
// One ICB link (command + response channels); master drives cmd, slave answers.
interface icb_arb_2m1s_if
  import icb_arb_2m1s_pkg::*;
#(
  parameter int AW = MemAddrBus,
  parameter int DW = MemBus
);
  logic            cmd_valid;
  logic            cmd_ready;
  logic [AW-1:0]   cmd_addr;
  logic            cmd_read;
  logic [DW-1:0]   cmd_wdata;
  logic [DW/8-1:0] cmd_wmask;
  logic            rsp_valid;
  logic            rsp_ready;
  logic            rsp_err;
  logic [DW-1:0]   rsp_rdata;

  modport master (
    output cmd_valid, cmd_addr, cmd_read, cmd_wdata, cmd_wmask, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_err, rsp_rdata
  );

  modport slave (
    input  cmd_valid, cmd_addr, cmd_read, cmd_wdata, cmd_wmask, rsp_ready,
    output cmd_ready, rsp_valid, rsp_err, rsp_rdata
  );
endinterface

// File: rtl/icb_arb_2m1s_rr_arb2.sv
// Combinational two-way pick: round-robin against 'last', or fixed with req[0] winning.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  input  logic       rr_en,
  output logic       winner
);

  always_comb begin
    winner = 1'b0;
    unique case (req)
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
      2'b11:   winner = rr_en ? ~last : 1'b0;
      default: winner = 1'b0;
    endcase
  end

endmodule

// File: rtl/icb_arb_2m1s.sv
// Two-master / one-slave ICB arbiter; grant is locked from command acceptance to response handshake.
module icb_arb_2m1s
  import icb_arb_2m1s_pkg::*;
#(
  parameter int AW    = MemAddrBus,
  parameter int DW    = MemBus,
  parameter int RR_EN = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  icb_arb_2m1s_if.slave  m0_icb,
  icb_arb_2m1s_if.slave  m1_icb,
  icb_arb_2m1s_if.master s_icb,
  output logic           grant,
  output logic           busy
);

  arb_state_e state_q, state_d;
  logic       grant_q, grant_d;
  logic       rr_last_q, rr_last_d;
  logic       winner;
  logic       sel;
  logic       sel_valid;
  logic       cmd_hs;
  logic       rsp_hs;

  logic [AW-1:0]   mux_addr;
  logic [DW-1:0]   mux_wdata;
  logic [DW/8-1:0] mux_wmask;
  logic            mux_read;

  rr_arb2 u_rr_arb2 (
    .req    ({m1_icb.cmd_valid, m0_icb.cmd_valid}),
    .last   (rr_last_q),
    .rr_en  (RR_EN != 0),
    .winner (winner)
  );

  // In IDLE the fresh arbitration result steers the path; otherwise the locked grant does.
  always_comb begin
    sel       = (state_q == ST_IDLE) ? winner : grant_q;
    sel_valid = sel ? m1_icb.cmd_valid : m0_icb.cmd_valid;
    mux_addr  = sel ? m1_icb.cmd_addr  : m0_icb.cmd_addr;
    mux_read  = sel ? m1_icb.cmd_read  : m0_icb.cmd_read;
    mux_wdata = sel ? m1_icb.cmd_wdata : m0_icb.cmd_wdata;
    mux_wmask = sel ? m1_icb.cmd_wmask : m0_icb.cmd_wmask;
  end

  always_comb begin
    s_icb.cmd_valid  = 1'b0;
    s_icb.cmd_addr   = mux_addr;
    s_icb.cmd_read   = mux_read;
    s_icb.cmd_wdata  = mux_wdata;
    s_icb.cmd_wmask  = mux_wmask;
    s_icb.rsp_ready  = 1'b0;
    m0_icb.cmd_ready = 1'b0;
    m1_icb.cmd_ready = 1'b0;
    m0_icb.rsp_valid = 1'b0;
    m0_icb.rsp_err   = 1'b0;
    m0_icb.rsp_rdata = '0;
    m1_icb.rsp_valid = 1'b0;
    m1_icb.rsp_err   = 1'b0;
    m1_icb.rsp_rdata = '0;

    unique case (state_q)
      ST_IDLE, ST_CMD: begin
        s_icb.cmd_valid = sel_valid;
        if (sel) m1_icb.cmd_ready = s_icb.cmd_ready;
        else     m0_icb.cmd_ready = s_icb.cmd_ready;
      end
      ST_RSP: begin
        if (grant_q) begin
          m1_icb.rsp_valid = s_icb.rsp_valid;
          m1_icb.rsp_err   = s_icb.rsp_err;
          m1_icb.rsp_rdata = s_icb.rsp_rdata;
          s_icb.rsp_ready  = m1_icb.rsp_ready;
        end else begin
          m0_icb.rsp_valid = s_icb.rsp_valid;
          m0_icb.rsp_err   = s_icb.rsp_err;
          m0_icb.rsp_rdata = s_icb.rsp_rdata;
          s_icb.rsp_ready  = m0_icb.rsp_ready;
        end
      end
      default: ;
    endcase

    // Handshake outputs are forced low for as long as reset is held, not just after the edge.
    if (!rst_n) begin
      s_icb.cmd_valid  = 1'b0;
      s_icb.rsp_ready  = 1'b0;
      m0_icb.cmd_ready = 1'b0;
      m1_icb.cmd_ready = 1'b0;
      m0_icb.rsp_valid = 1'b0;
      m1_icb.rsp_valid = 1'b0;
      m0_icb.rsp_err   = 1'b0;
      m1_icb.rsp_err   = 1'b0;
    end
  end

  assign cmd_hs = s_icb.cmd_valid & s_icb.cmd_ready;
  assign rsp_hs = s_icb.rsp_valid & s_icb.rsp_ready;

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_last_d = rr_last_q;
    unique case (state_q)
      ST_IDLE: begin
        if (sel_valid) begin
          grant_d = winner;
          state_d = cmd_hs ? ST_RSP : ST_CMD;
        end
      end
      ST_CMD: begin
        if (cmd_hs) state_d = ST_RSP;
      end
      ST_RSP: begin
        if (rsp_hs) begin
          rr_last_d = grant_q;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      grant_q   <= 1'b0;
      rr_last_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_last_q <= rr_last_d;
    end
  end

  assign grant = grant_q;
  assign busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_icb_arb_2m1s.sv
// Directed bench for icb_arb_2m1s: a round-robin instance plus a fixed-priority twin on shared stimulus.
module tb_icb_arb_2m1s;

  localparam logic [31:0] M0_ADDR = 32'h0000_0100;
  localparam logic [31:0] M1_ADDR = 32'h0000_0200;
  localparam logic [31:0] M0_DATA = 32'h1111_1111;
  localparam logic [31:0] M1_DATA = 32'h2222_2222;

  logic clk = 1'b0;
  logic rst_n;
  logic grant, busy, grant_f, busy_f;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  icb_arb_2m1s_if #(.AW(32), .DW(32)) m0 ();
  icb_arb_2m1s_if #(.AW(32), .DW(32)) m1 ();
  icb_arb_2m1s_if #(.AW(32), .DW(32)) s ();
  icb_arb_2m1s_if #(.AW(32), .DW(32)) m0f ();
  icb_arb_2m1s_if #(.AW(32), .DW(32)) m1f ();
  icb_arb_2m1s_if #(.AW(32), .DW(32)) sf ();

  icb_arb_2m1s #(.AW(32), .DW(32), .RR_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .m0_icb(m0), .m1_icb(m1), .s_icb(s),
    .grant(grant), .busy(busy)
  );

  icb_arb_2m1s #(.AW(32), .DW(32), .RR_EN(0)) dut_fp (
    .clk(clk), .rst_n(rst_n), .m0_icb(m0f), .m1_icb(m1f), .s_icb(sf),
    .grant(grant_f), .busy(busy_f)
  );

  // The fixed-priority twin sees exactly the same master and slave stimulus.
  assign m0f.cmd_valid = m0.cmd_valid;
  assign m0f.cmd_addr  = m0.cmd_addr;
  assign m0f.cmd_read  = m0.cmd_read;
  assign m0f.cmd_wdata = m0.cmd_wdata;
  assign m0f.cmd_wmask = m0.cmd_wmask;
  assign m0f.rsp_ready = m0.rsp_ready;
  assign m1f.cmd_valid = m1.cmd_valid;
  assign m1f.cmd_addr  = m1.cmd_addr;
  assign m1f.cmd_read  = m1.cmd_read;
  assign m1f.cmd_wdata = m1.cmd_wdata;
  assign m1f.cmd_wmask = m1.cmd_wmask;
  assign m1f.rsp_ready = m1.rsp_ready;
  assign sf.cmd_ready  = s.cmd_ready;
  assign sf.rsp_valid  = s.rsp_valid;
  assign sf.rsp_err    = s.rsp_err;
  assign sf.rsp_rdata  = s.rsp_rdata;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0.cmd_valid = 1'b0; m0.cmd_addr = M0_ADDR; m0.cmd_read = 1'b1;
    m0.cmd_wdata = '0;   m0.cmd_wmask = '0;     m0.rsp_ready = 1'b1;
    m1.cmd_valid = 1'b0; m1.cmd_addr = M1_ADDR; m1.cmd_read = 1'b1;
    m1.cmd_wdata = '0;   m1.cmd_wmask = '0;     m1.rsp_ready = 1'b1;
    s.cmd_ready = 1'b0;  s.rsp_valid = 1'b0; s.rsp_err = 1'b0; s.rsp_rdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    checks++;
    if ({busy, grant, busy_f, grant_f} !== 4'b0000) begin
      errors++; $display("FAIL reset_state got busy/grant/busy_f/grant_f=%b exp 0000", {busy, grant, busy_f, grant_f});
    end
    checks++;
    if ({m0.cmd_ready, m1.cmd_ready, m0.rsp_valid, m1.rsp_valid, s.cmd_valid, s.rsp_ready} !== 6'b0) begin
      errors++; $display("FAIL reset_handshakes got %b exp 000000",
                         {m0.cmd_ready, m1.cmd_ready, m0.rsp_valid, m1.rsp_valid, s.cmd_valid, s.rsp_ready});
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_master();
    do_reset();
    m1.cmd_valid = 1'b1; m1.cmd_addr = 32'h2000_0010; m1.cmd_read = 1'b1;
    s.cmd_ready = 1'b1;
    #1;
    checks++;
    if ({s.cmd_valid, s.cmd_read, s.cmd_addr} !== {2'b11, 32'h2000_0010}) begin
      errors++; $display("FAIL single_fwd got v/r/addr=%b/%b/%h exp 1/1/20000010", s.cmd_valid, s.cmd_read, s.cmd_addr);
    end
    checks++;
    if ({m1.cmd_ready, m0.cmd_ready} !== 2'b10) begin
      errors++; $display("FAIL single_cmd_ready got %b exp 10", {m1.cmd_ready, m0.cmd_ready});
    end
    tick();
    m1.cmd_valid = 1'b0; s.cmd_ready = 1'b0;
    for (int unsigned c = 0; c < 2; c++) begin
      #1;
      checks++;
      if ({busy, grant, m1.rsp_valid, s.cmd_valid} !== 4'b1100) begin
        errors++; $display("FAIL single_wait%0d got busy/grant/rspv/scv=%b exp 1100", c, {busy, grant, m1.rsp_valid, s.cmd_valid});
      end
      tick();
    end
    s.rsp_valid = 1'b1; s.rsp_rdata = 32'hDEAD_BEEF;
    #1;
    checks++;
    if ({m1.rsp_valid, m0.rsp_valid, s.rsp_ready, m1.rsp_rdata} !== {3'b101, 32'hDEAD_BEEF}) begin
      errors++; $display("FAIL single_rsp got m1v/m0v/srdy/rdata=%b/%b/%b/%h exp 1/0/1/deadbeef",
                         m1.rsp_valid, m0.rsp_valid, s.rsp_ready, m1.rsp_rdata);
    end
    checks++;
    if (m0.rsp_rdata !== 32'h0) begin
      errors++; $display("FAIL single_m0_rdata got %h exp 00000000", m0.rsp_rdata);
    end
    tick();
    s.rsp_valid = 1'b0;
    checks++;
    if ({busy, grant} !== 2'b01) begin
      errors++; $display("FAIL single_done got busy/grant=%b exp 01", {busy, grant});
    end
  endtask

  task automatic test_round_robin();
    logic exp_order [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] cap;
    do_reset();
    m0.cmd_valid = 1'b1; m1.cmd_valid = 1'b1; s.cmd_ready = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      s.rsp_valid = 1'b0;
      #1;
      checks++;
      if (s.cmd_addr !== (exp_order[i] ? M1_ADDR : M0_ADDR) ||
          {m1.cmd_ready, m0.cmd_ready} !== (exp_order[i] ? 2'b10 : 2'b01)) begin
        errors++; $display("FAIL rr_pick%0d got addr=%h rdy=%b exp master %0d", i, s.cmd_addr,
                           {m1.cmd_ready, m0.cmd_ready}, exp_order[i]);
      end
      cap = s.cmd_addr;
      tick();
      s.rsp_valid = 1'b1;
      s.rsp_rdata = (cap == M1_ADDR) ? M1_DATA : M0_DATA;
      #1;
      checks++;
      if (grant !== exp_order[i] || busy !== 1'b1 || s.cmd_valid !== 1'b0) begin
        errors++; $display("FAIL rr_grant%0d got grant=%b busy=%b scv=%b exp %b 1 0", i, grant, busy, s.cmd_valid, exp_order[i]);
      end
      checks++;
      if (exp_order[i] ? ({m1.rsp_valid, m0.rsp_valid, m1.rsp_rdata} !== {2'b10, M1_DATA})
                       : ({m1.rsp_valid, m0.rsp_valid, m0.rsp_rdata} !== {2'b01, M0_DATA})) begin
        errors++; $display("FAIL rr_rsp%0d got v=%b m0=%h m1=%h exp master %0d own data", i,
                           {m1.rsp_valid, m0.rsp_valid}, m0.rsp_rdata, m1.rsp_rdata, exp_order[i]);
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_fixed_priority();
    do_reset();
    m0.cmd_valid = 1'b1; m1.cmd_valid = 1'b1; s.cmd_ready = 1'b1;
    for (int unsigned i = 0; i < 3; i++) begin
      s.rsp_valid = 1'b0;
      #1;
      checks++;
      if (sf.cmd_addr !== M0_ADDR || {m1f.cmd_ready, m0f.cmd_ready} !== 2'b01) begin
        errors++; $display("FAIL fp_pick%0d got addr=%h rdy=%b exp %h 01", i, sf.cmd_addr, {m1f.cmd_ready, m0f.cmd_ready}, M0_ADDR);
      end
      tick();
      s.rsp_valid = 1'b1; s.rsp_rdata = M0_DATA;
      #1;
      checks++;
      if ({grant_f, busy_f, m1f.cmd_ready, m0f.rsp_valid, m1f.rsp_valid} !== 5'b01010 || m0f.rsp_rdata !== M0_DATA) begin
        errors++; $display("FAIL fp_rsp%0d got g/b/m1rdy/m0v/m1v=%b rdata=%h exp 01010 %h", i,
                           {grant_f, busy_f, m1f.cmd_ready, m0f.rsp_valid, m1f.rsp_valid}, m0f.rsp_rdata, M0_DATA);
      end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_cmd_backpressure();
    do_reset();
    m0.cmd_valid = 1'b1; s.cmd_ready = 1'b0;
    #1;
    checks++;
    if ({s.cmd_valid, m0.cmd_ready} !== 2'b10) begin
      errors++; $display("FAIL bp_first got scv/m0rdy=%b exp 10", {s.cmd_valid, m0.cmd_ready});
    end
    tick();
    for (int unsigned c = 1; c <= 3; c++) begin
      if (c >= 2) m1.cmd_valid = 1'b1;
      #1;
      checks++;
      if ({busy, grant, m1.cmd_ready, m0.cmd_ready} !== 4'b1000 || s.cmd_addr !== M0_ADDR) begin
        errors++; $display("FAIL bp_hold%0d got busy/grant/m1rdy/m0rdy=%b addr=%h exp 1000 %h", c,
                           {busy, grant, m1.cmd_ready, m0.cmd_ready}, s.cmd_addr, M0_ADDR);
      end
      tick();
    end
    s.cmd_ready = 1'b1;
    #1;
    checks++;
    if ({m0.cmd_ready, m1.cmd_ready, s.cmd_valid} !== 3'b101) begin
      errors++; $display("FAIL bp_accept got m0rdy/m1rdy/scv=%b exp 101", {m0.cmd_ready, m1.cmd_ready, s.cmd_valid});
    end
    tick();
    m0.cmd_valid = 1'b0;
    s.rsp_valid = 1'b1; s.rsp_rdata = M0_DATA;
    tick();
    s.rsp_valid = 1'b0;
    #1;
    checks++;
    if (s.cmd_addr !== M1_ADDR || m1.cmd_ready !== 1'b1) begin
      errors++; $display("FAIL bp_next got addr=%h m1rdy=%b exp %h 1", s.cmd_addr, m1.cmd_ready, M1_ADDR);
    end
    tick();
    checks++;
    if ({busy, grant} !== 2'b11) begin
      errors++; $display("FAIL bp_next_grant got busy/grant=%b exp 11", {busy, grant});
    end
    m1.cmd_valid = 1'b0;
    s.rsp_valid = 1'b1;
    tick();
    idle_inputs();
  endtask

  task automatic test_rsp_backpressure();
    do_reset();
    m0.cmd_valid = 1'b1; m0.cmd_read = 1'b0; m0.cmd_wdata = 32'hA5A5_0F0F; m0.cmd_wmask = 4'b0101;
    s.cmd_ready = 1'b1;
    #1;
    checks++;
    if ({s.cmd_read, s.cmd_wdata, s.cmd_wmask} !== {1'b0, 32'hA5A5_0F0F, 4'b0101}) begin
      errors++; $display("FAIL wr_fwd got r/wdata/wmask=%b/%h/%b exp 0/a5a50f0f/0101", s.cmd_read, s.cmd_wdata, s.cmd_wmask);
    end
    tick();
    m0.cmd_valid = 1'b0;
    s.rsp_valid = 1'b1; s.rsp_err = 1'b1; m0.rsp_ready = 1'b0;
    for (int unsigned c = 0; c < 2; c++) begin
      #1;
      checks++;
      if ({s.rsp_ready, busy, m0.rsp_valid, m0.rsp_err, m1.rsp_err} !== 5'b01110) begin
        errors++; $display("FAIL rsp_bp%0d got srdy/busy/m0v/m0err/m1err=%b exp 01110", c,
                           {s.rsp_ready, busy, m0.rsp_valid, m0.rsp_err, m1.rsp_err});
      end
      tick();
    end
    m0.rsp_ready = 1'b1;
    tick();
    s.rsp_valid = 1'b0; s.rsp_err = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL rsp_bp_done got busy=%b exp 0", busy);
    end
    s.rsp_valid = 1'b1; s.rsp_rdata = 32'hFFFF_FFFF;
    #1;
    checks++;
    if ({m0.rsp_valid, m1.rsp_valid, s.rsp_ready} !== 3'b000) begin
      errors++; $display("FAIL stray_rsp got m0v/m1v/srdy=%b exp 000", {m0.rsp_valid, m1.rsp_valid, s.rsp_ready});
    end
    tick();
    s.rsp_valid = 1'b0;
    checks++;
    if ({busy, grant} !== 2'b00) begin
      errors++; $display("FAIL stray_state got busy/grant=%b exp 00", {busy, grant});
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_rsp();
    do_reset();
    m1.cmd_valid = 1'b1; s.cmd_ready = 1'b1;
    tick();
    m1.cmd_valid = 1'b0;
    checks++;
    if ({busy, grant} !== 2'b11) begin
      errors++; $display("FAIL mid_pre got busy/grant=%b exp 11", {busy, grant});
    end
    m0.cmd_valid = 1'b1; m1.cmd_valid = 1'b1; s.rsp_valid = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, grant} !== 2'b00) begin
      errors++; $display("FAIL mid_reset_state got busy/grant=%b exp 00", {busy, grant});
    end
    checks++;
    if ({m0.cmd_ready, m1.cmd_ready, m0.rsp_valid, m1.rsp_valid, s.cmd_valid, s.rsp_ready} !== 6'b0) begin
      errors++; $display("FAIL mid_reset_outputs got %b exp 000000",
                         {m0.cmd_ready, m1.cmd_ready, m0.rsp_valid, m1.rsp_valid, s.cmd_valid, s.rsp_ready});
    end
    s.rsp_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (s.cmd_addr !== M0_ADDR || {m1.cmd_ready, m0.cmd_ready} !== 2'b01) begin
      errors++; $display("FAIL post_reset_pick got addr=%h rdy=%b exp %h 01", s.cmd_addr, {m1.cmd_ready, m0.cmd_ready}, M0_ADDR);
    end
    tick();
    checks++;
    if ({busy, grant} !== 2'b10) begin
      errors++; $display("FAIL post_reset_grant got busy/grant=%b exp 10", {busy, grant});
    end
    idle_inputs();
    s.rsp_valid = 1'b1;
    tick();
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    test_reset();
    test_single_master();
    test_round_robin();
    test_fixed_priority();
    test_cmd_backpressure();
    test_rsp_backpressure();
    test_reset_mid_rsp();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/icb_arb_2m1s.md
Name: icb_arb_2m1s

Overview:
Two-master, one-slave ICB arbiter. It shares one slave port, for example a single memory or peripheral behind the bus bridge, between the core ICB master and the JTAG debug ICB master. At most one transaction is outstanding. The grant is locked from command acceptance until the response handshake completes. Priority is round-robin or fixed, selected by a parameter.

Parameters:
AW, 32, ICB address width
DW, 32, ICB data width (wmask width = DW/8)
RR_EN, 1, 1 = round-robin, 0 = fixed priority (m0 wins)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous reset, active-low
mN_icb_cmd_valid  input  1  master N command valid (N = 0, 1)
mN_icb_cmd_ready  output  1  master N command ready
mN_icb_cmd_addr  input  AW  master N address
mN_icb_cmd_read  input  1  master N read=1 / write=0
mN_icb_cmd_wdata  input  DW  master N write data
mN_icb_cmd_wmask  input  DW/8  master N byte mask
mN_icb_rsp_valid  output  1  master N response valid
mN_icb_rsp_ready  input  1  master N response ready
mN_icb_rsp_err  output  1  master N response error
mN_icb_rsp_rdata  output  DW  master N read data
s_icb_cmd_valid/ready/addr/read/wdata/wmask  out/in/out/out/out/out  1/1/AW/1/DW/DW/8  slave command channel
s_icb_rsp_valid/ready/err/rdata  in/out/in/in  1/1/1/DW  slave response channel
grant  output  1  current or last granted master index
busy  output  1  high in CMD or RSP state

Behaviour:
- Handshake: a transfer occurs on a cycle where valid and ready are both high. Masters hold valid and payload until ready.
- States: IDLE, CMD, RSP. Reset enters IDLE, sets rr_last=1 (so m0 is favoured first), grant=0, busy=0. All ready and valid outputs are 0 in reset, except as noted under IDLE.
- IDLE, arbitration (combinational):
  - Only one master valid: that master wins.
  - Both valid, RR_EN=1: the master other than rr_last wins.
  - Both valid, RR_EN=0: m0 wins.
- IDLE, forwarding:
  - The winner's cmd is forwarded to the slave in the same cycle (zero-latency path). s_icb_cmd_valid equals the winner's valid.
  - Winner's cmd_ready = s_icb_cmd_ready. Loser's cmd_ready = 0.
- IDLE, transitions:
  - Slave cmd handshake this cycle: latch grant, go to RSP.
  - Valid present but no handshake: latch grant, go to CMD.
- CMD: the latched master is muxed to the slave. Grant is frozen; a newly valid other master cannot steal it. Slave cmd handshake → RSP.
- RSP:
  - s_icb_cmd_valid=0. Both masters' cmd_ready=0.
  - Granted master: rsp_valid/err/rdata = slave's; s_icb_rsp_ready = granted master's rsp_ready.
  - Response handshake: rr_last <= grant, go to IDLE.
  - Minimum throughput is one transaction per 2 cycles.
- Non-granted master always sees rsp_valid=0, err=0, rdata=0.
- In IDLE/CMD, s_icb_rsp_ready=0. A stray slave rsp_valid is ignored and does not change state.
- grant holds its value after returning to IDLE until the next arbitration.
- busy = (state != IDLE).
- Reset asserted mid-transaction (CMD or RSP): immediate return to IDLE, with every output at its reset value. The in-flight transaction is dropped; the slave is reset by the same rst_n.
- No internal timeout: a slave that never responds stalls the arbiter by design.

Decomposition:
- Shared package/defines: ICB field widths (MemAddrBus, MemBus, wmask = 4) and the state encoding (IDLE=2'd0, CMD=2'd1, RSP=2'd2).
- Sub-module rr_arb2: combinational 2-way round-robin/fixed pick, with inputs req[1:0], last, rr_en and output winner. Everything else lives in the top module.

Test Plan:
- Single master: m1 reads addr 0x2000_0010; slave accepts at once and responds 2 cycles later with rdata 0xDEAD_BEEF → m1 gets rsp_valid with rdata 0xDEAD_BEEF. m0 rsp_valid stays 0. grant=1, busy high for exactly 2+ cycles.
- Simultaneous requests, RR_EN=1, from reset: both valid every cycle for 4 transactions → grant order 0,1,0,1. Each master gets exactly its own rdata (0x1111_1111 for m0, 0x2222_2222 for m1).
- Simultaneous requests, RR_EN=0: both valid continuously for 3 transactions → m0 granted all 3, m1 cmd_ready stays 0 throughout.
- Slave backpressure: s_icb_cmd_ready low 3 cycles while m0 waits; m1 raises valid in cycle 2 → FSM holds CMD with grant=0. m0 handshakes in cycle 4, then m1 is served next.
- Response backpressure and stray response: m0 rsp_ready low 2 cycles → s_icb_rsp_ready low, FSM stays in RSP. A slave rsp_valid pulse injected in IDLE → no master rsp_valid, state unchanged.
- Reset mid-RSP: assert rst_n=0 while in RSP with grant=1 → same-cycle busy=0, all readys/valids 0. After release, a simultaneous request is granted to m0.
